// File: rtl/sync_fifo_param_if.sv
// Handshake bundle between a producer/consumer pair and sync_fifo_param.
// master = the side that writes, reads and clears errors; slave = the FIFO.
interface sync_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              wr;
    logic [DATA_W-1:0] data_in;
    logic              rd;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              clr_err;
    logic              fifo_full;
    logic              fifo_empty;
    logic              almost_full;
    logic              almost_empty;
    logic              fifo_overflow;
    logic              fifo_underflow;
    logic [ADDR_W:0]   fill_level;

    modport master (
        output wr, data_in, rd, clr_err,
        input  data_out, rd_valid, fifo_full, fifo_empty, almost_full,
               almost_empty, fifo_overflow, fifo_underflow, fill_level
    );

    modport slave (
        input  wr, data_in, rd, clr_err,
        output data_out, rd_valid, fifo_full, fifo_empty, almost_full,
               almost_empty, fifo_overflow, fifo_underflow, fill_level
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: registered read data, fill level,
// programmable almost flags and sticky overflow/underflow errors.
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    sync_fifo_param_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int PTR_W = ADDR_W + 1;

    localparam logic [PTR_W-1:0] LVL_FULL = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] LVL_AF   = PTR_W'(AF_LEVEL);
    localparam logic [PTR_W-1:0] LVL_AE   = PTR_W'(AE_LEVEL);

    if (DATA_W < 1 || ADDR_W < 1) begin : g_bad_size
        $error("sync_fifo_param: DATA_W and ADDR_W must be >= 1");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("sync_fifo_param: AF_LEVEL must lie in 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_param: AE_LEVEL must lie in 0..DEPTH-1");
    end

    // Set has priority over clear so an error in the clearing cycle is not lost.
    function automatic logic sticky_next(input logic cur, input logic set,
                                         input logic clr);
        return set | (cur & ~clr);
    endfunction

    function automatic logic [PTR_W-1:0] level_next(input logic [PTR_W-1:0] lvl,
                                                    input logic inc,
                                                    input logic dec);
        logic [PTR_W-1:0] res;
        res = lvl;
        if (inc && !dec)      res = lvl + PTR_W'(1);
        else if (dec && !inc) res = lvl - PTR_W'(1);
        return res;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [PTR_W-1:0]  level;
    logic              full;
    logic              empty;
    logic              we;
    logic              re;
    logic [DATA_W-1:0] rdata_p1;
    logic              vld_p1;
    logic              ovf;
    logic              unf;

    // Flags come only from the registered level, never from wr/rd.
    assign full  = (level == LVL_FULL);
    assign empty = (level == '0);
    assign we    = bus.wr & ~full;
    assign re    = bus.rd & ~empty;

    always_ff @(posedge clk) begin
        if (we) mem[wptr[ADDR_W-1:0]] <= bus.data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            if (we) wptr <= wptr + PTR_W'(1);
            if (re) rptr <= rptr + PTR_W'(1);
            level <= level_next(level, we, re);
            ovf   <= sticky_next(ovf, bus.wr & full,  bus.clr_err);
            unf   <= sticky_next(unf, bus.rd & empty, bus.clr_err);
        end
    end

    // ---- read stage p1: registered data plus its valid pulse ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_p1 <= '0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= re;
            if (re) rdata_p1 <= mem[rptr[ADDR_W-1:0]];
        end
    end

    assign bus.data_out       = rdata_p1;
    assign bus.rd_valid       = vld_p1;
    assign bus.fifo_full      = full;
    assign bus.fifo_empty     = empty;
    assign bus.almost_full    = (level >= LVL_AF);
    assign bus.almost_empty   = (level <= LVL_AE);
    assign bus.fifo_overflow  = ovf;
    assign bus.fifo_underflow = unf;
    assign bus.fill_level     = level;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: default 8x16 instance and a
// 32x8 instance with AF=6/AE=1, scoreboard queues for read data.
module tb_sync_fifo_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_W(8),  .ADDR_W(4)) a();
    sync_fifo_param_if #(.DATA_W(32), .ADDR_W(3)) b();

    sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .AF_LEVEL(12), .AE_LEVEL(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(a)
    );
    sync_fifo_param #(.DATA_W(32), .ADDR_W(3), .AF_LEVEL(6), .AE_LEVEL(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(b)
    );

    int total = 0;
    int bad   = 0;

    int         m_level = 0;
    bit         m_ovf = 1'b0, m_unf = 1'b0;
    logic [7:0] q[$];
    int         m2_level = 0;
    bit         m2_ovf = 1'b0;
    logic [31:0] q2[$];

    typedef struct {
        logic       w, r, c;
        logic [7:0] d;
        int         lvl;
        logic       ovf, unf;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
        logic       xwe, xre;
        logic [7:0] xd;
        @(negedge clk);
        a.wr = w; a.rd = r; a.clr_err = c; a.data_in = d;
        xwe = w && (m_level != 16);
        xre = r && (m_level != 0);
        xd  = '0;
        m_ovf = (w && m_level == 16) || (m_ovf && !c);
        m_unf = (r && m_level == 0)  || (m_unf && !c);
        if (xre) xd = q.pop_front();
        if (xwe) q.push_back(d);
        m_level += int'(xwe) - int'(xre);
        @(posedge clk); #1;
        chk("a_rd_valid", 32'(a.rd_valid), 32'(xre));
        if (xre) chk("a_data_out", 32'(a.data_out), 32'(xd));
        chk("a_level", 32'(a.fill_level), 32'(m_level));
        chk("a_full",  32'(a.fifo_full),    32'(m_level == 16));
        chk("a_empty", 32'(a.fifo_empty),   32'(m_level == 0));
        chk("a_af",    32'(a.almost_full),  32'(m_level >= 12));
        chk("a_ae",    32'(a.almost_empty), 32'(m_level <= 4));
        chk("a_ovf",   32'(a.fifo_overflow),  32'(m_ovf));
        chk("a_unf",   32'(a.fifo_underflow), 32'(m_unf));
    endtask

    task automatic step2(input logic w, input logic r, input logic c, input logic [31:0] d);
        logic        xwe, xre;
        logic [31:0] xd;
        @(negedge clk);
        b.wr = w; b.rd = r; b.clr_err = c; b.data_in = d;
        xwe = w && (m2_level != 8);
        xre = r && (m2_level != 0);
        xd  = '0;
        m2_ovf = (w && m2_level == 8) || (m2_ovf && !c);
        if (xre) xd = q2.pop_front();
        if (xwe) q2.push_back(d);
        m2_level += int'(xwe) - int'(xre);
        @(posedge clk); #1;
        chk("b_rd_valid", 32'(b.rd_valid), 32'(xre));
        if (xre) chk("b_data_out", b.data_out, xd);
        chk("b_level", 32'(b.fill_level),   32'(m2_level));
        chk("b_full",  32'(b.fifo_full),    32'(m2_level == 8));
        chk("b_empty", 32'(b.fifo_empty),   32'(m2_level == 0));
        chk("b_af",    32'(b.almost_full),  32'(m2_level >= 6));
        chk("b_ae",    32'(b.almost_empty), 32'(m2_level <= 1));
        chk("b_ovf",   32'(b.fifo_overflow), 32'(m2_ovf));
    endtask

    task automatic idle_all();
        a.wr = 1'b0; a.rd = 1'b0; a.clr_err = 1'b0; a.data_in = '0;
        b.wr = 1'b0; b.rd = 1'b0; b.clr_err = 1'b0; b.data_in = '0;
    endtask

    task automatic check_reset_a(input string tag);
        chk({tag, "_level"},    32'(a.fill_level),     32'd0);
        chk({tag, "_empty"},    32'(a.fifo_empty),     32'd1);
        chk({tag, "_ae"},       32'(a.almost_empty),   32'd1);
        chk({tag, "_full"},     32'(a.fifo_full),      32'd0);
        chk({tag, "_af"},       32'(a.almost_full),    32'd0);
        chk({tag, "_data_out"}, 32'(a.data_out),       32'd0);
        chk({tag, "_rd_valid"}, 32'(a.rd_valid),       32'd0);
        chk({tag, "_ovf"},      32'(a.fifo_overflow),  32'd0);
        chk({tag, "_unf"},      32'(a.fifo_underflow), 32'd0);
    endtask

    task automatic apply_vec(input int i);
        step(tbl[i].w, tbl[i].r, tbl[i].c, tbl[i].d);
        chk($sformatf("tbl%0d_level", i), 32'(a.fill_level),     32'(tbl[i].lvl));
        chk($sformatf("tbl%0d_ovf", i),   32'(a.fifo_overflow),  32'(tbl[i].ovf));
        chk($sformatf("tbl%0d_unf", i),   32'(a.fifo_underflow), 32'(tbl[i].unf));
    endtask

    initial begin
        //              w     r     c     d      lvl ovf   unf
        tbl[0] = '{1'b1, 1'b1, 1'b0, 8'hAA, 15, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 14, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 8'h00, 13, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 8'h00, 13, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 8'h55,  1, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 8'h00,  0, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 8'h00,  0, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 8'h00,  0, 1'b0, 1'b0};

        idle_all();
        repeat (2) @(posedge clk);
        #1;
        check_reset_a("rst0");
        chk("rst0_b_empty", 32'(b.fifo_empty), 32'd1);
        @(negedge clk) rst_n = 1'b1;

        // Asynchronous reset mid-clock after 5 writes and one read.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'(8'hE0 + i));
        step(1'b0, 1'b1, 1'b0, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        check_reset_a("rst_mid");
        idle_all();
        q.delete(); m_level = 0; m_ovf = 1'b0; m_unf = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        // Fill 0x01..0x10, then drain in order.
        for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 1'b0, 8'(i));
        chk("fill_full", 32'(a.fifo_full), 32'd1);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("drain_empty", 32'(a.fifo_empty), 32'd1);

        // Overflow with simultaneous read, sticky until clear.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
        for (int i = 0; i < 4; i++) apply_vec(i);
        for (int i = 0; i < 13; i++) step(1'b0, 1'b1, 1'b0, 8'h00);

        // Underflow with simultaneous write; clear-vs-set priority.
        for (int i = 4; i < 8; i++) apply_vec(i);

        // Wrap-around at steady level 3.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h43 + i));
        chk("wrap_level", 32'(a.fill_level), 32'd3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
        @(negedge clk) idle_all();

        // 32-bit, depth-8 instance with AF=6, AE=1.
        for (int i = 0; i < 8; i++) begin
            step2(1'b1, 1'b0, 1'b0, $urandom);
            if (i == 0) chk("b_ae_at1", 32'(b.almost_empty), 32'd1);
            if (i == 1) chk("b_ae_at2", 32'(b.almost_empty), 32'd0);
            if (i == 4) chk("b_af_at5", 32'(b.almost_full),  32'd0);
            if (i == 5) chk("b_af_at6", 32'(b.almost_full),  32'd1);
        end
        chk("b_full_at8", 32'(b.fifo_full), 32'd1);
        step2(1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
        chk("b_ovf_set", 32'(b.fifo_overflow), 32'd1);
        step2(1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
        chk("b_ovf_setwins", 32'(b.fifo_overflow), 32'd1);
        step2(1'b0, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 8; i++) step2(1'b0, 1'b1, 1'b0, 32'h0);
        chk("b_empty_end", 32'(b.fifo_empty), 32'd1);
        @(negedge clk) idle_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
